alu_imm_sequencer: RTL and testbench

- Control-step sequencer for the ALU-immediate instruction class: addi, andi and ori.
- Drives the DataPath control strobes through fetch (T0-T2), decode and execute (T3-T5).
- Replaces the hand-coded per-instruction state sequencing.
- Generalised over opcode assignment, memory read latency and single/continuous run mode; flags unsupported opcodes.

---
 rtl/alu_imm_sequencer_if.sv | 36 +++
 rtl/alu_imm_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_imm_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_imm_sequencer_if.sv
// Control-step bundle between the ALU-immediate sequencer and the DataPath.
// The sequencer is the master: it reads start/run/opcode and drives the strobes.
interface alu_imm_sequencer_if #(
    parameter int OPC_W = 5
);
    logic             start;
    logic             run;
    logic             mem_ready;
    logic [OPC_W-1:0] ir_opcode;

    logic PCout, MARin, IncPC, Zin, PCin;
    logic ram_read, MDRin, MDRout, IRin;
    logic Grb, Gra, Rout, Rin, Yin, Cout, Zlowout;

    logic [1:0] alu_op;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic       illegal;

    modport master (
        input  start, run, mem_ready, ir_opcode,
        output PCout, MARin, IncPC, Zin, PCin,
        output ram_read, MDRin, MDRout, IRin,
        output Grb, Gra, Rout, Rin, Yin, Cout, Zlowout,
        output alu_op, step, busy, done, illegal
    );

    modport slave (
        output start, run, mem_ready, ir_opcode,
        input  PCout, MARin, IncPC, Zin, PCin,
        input  ram_read, MDRin, MDRout, IRin,
        input  Grb, Gra, Rout, Rin, Yin, Cout, Zlowout,
        input  alu_op, step, busy, done, illegal
    );
endinterface

// File: rtl/alu_imm_sequencer.sv
// Moore control-step sequencer for addi/andi/ori: fetch T0-T2, decode, T3-T5.
// Define ALU_IMM_SEQ_MEM_READY_EN to make the fetch read wait on mem_ready.
module alu_imm_sequencer #(
    parameter int               OPC_W    = 5,
    parameter logic [OPC_W-1:0] OPC_ADDI = 5'b01100,
    parameter logic [OPC_W-1:0] OPC_ANDI = 5'b01101,
    parameter logic [OPC_W-1:0] OPC_ORI  = 5'b01110,
    parameter int               MEM_LAT  = 1
) (
    input logic clock,
    input logic clear_n,
    alu_imm_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_DEC  = 4'd5,
        S_T3   = 4'd6,
        S_T4   = 4'd7,
        S_T5   = 4'd8,
        S_ERR  = 4'd9
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] alu_op_q, alu_op_d;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            alu_op_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
        end
    end

`ifndef ALU_IMM_SEQ_MEM_READY_EN
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_op_d = alu_op_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                cnt_d = 4'd1;
`ifdef ALU_IMM_SEQ_MEM_READY_EN
                state_d = (MEM_LAT == 1 && bus.mem_ready) ? S_T2 : S_T1W;
`else
                state_d = (MEM_LAT == 1) ? S_T2 : S_T1W;
`endif
            end
            S_T1W: begin
                // saturate so an unbounded mem_ready wait cannot wrap
                if (cnt_q != 4'hf) cnt_d = cnt_q + 4'd1;
`ifdef ALU_IMM_SEQ_MEM_READY_EN
                if (bus.mem_ready && cnt_q >= LAT_M1) state_d = S_T2;
`else
                if (cnt_q == LAT_M1) state_d = S_T2;
`endif
            end
            S_T2: state_d = S_DEC;
            S_DEC: begin
                unique case (1'b1)
                    (bus.ir_opcode == OPC_ADDI): begin
                        alu_op_d = 2'b00;
                        state_d  = S_T3;
                    end
                    (bus.ir_opcode == OPC_ANDI): begin
                        alu_op_d = 2'b01;
                        state_d  = S_T3;
                    end
                    (bus.ir_opcode == OPC_ORI): begin
                        alu_op_d = 2'b10;
                        state_d  = S_T3;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_T3:  state_d = S_T4;
            S_T4:  state_d = S_T5;
            S_T5:  state_d = bus.run ? S_T0 : S_IDLE;
            S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.ram_read = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Grb      = 1'b0;
        bus.Gra      = 1'b0;
        bus.Rout     = 1'b0;
        bus.Rin      = 1'b0;
        bus.Yin      = 1'b0;
        bus.Cout     = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.alu_op   = 2'b00;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        bus.step     = state_q;
        bus.busy     = (state_q != S_IDLE);
        unique case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.Zlowout  = 1'b1;
                bus.PCin     = 1'b1;
                bus.ram_read = 1'b1;
                bus.MDRin    = 1'b1;
            end
            S_T1W: begin
                bus.ram_read = 1'b1;
                bus.MDRin    = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                bus.Grb  = 1'b1;
                bus.Rout = 1'b1;
                bus.Yin  = 1'b1;
            end
            S_T4: begin
                bus.Cout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = alu_op_q;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                bus.done    = 1'b1;
            end
            S_ERR: bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_imm_sequencer.sv
// Directed bench for alu_imm_sequencer: MEM_LAT=1, 4 and 2 instances.
// Checks state, strobes, alu_op and flags each cycle plus bus exclusivity.
module tb_alu_imm_sequencer;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    alu_imm_sequencer_if if1 ();
    alu_imm_sequencer_if if4 ();
    alu_imm_sequencer_if if2 ();

    alu_imm_sequencer #(.MEM_LAT(1)) u1 (
        .clock(clock), .clear_n(clear_n), .bus(if1.master));
    alu_imm_sequencer #(.MEM_LAT(4)) u4 (
        .clock(clock), .clear_n(clear_n), .bus(if4.master));
    alu_imm_sequencer #(.MEM_LAT(2)) u2 (
        .clock(clock), .clear_n(clear_n), .bus(if2.master));

    // strobe order: PCout MARin IncPC Zin PCin ram_read MDRin MDRout
    //               IRin Grb Gra Rout Rin Yin Cout Zlowout
    localparam logic [15:0] SN  = 16'h0000;
    localparam logic [15:0] ST0 = 16'hF000;
    localparam logic [15:0] ST1 = 16'h0E01;
    localparam logic [15:0] STW = 16'h0600;
    localparam logic [15:0] ST2 = 16'h0180;
    localparam logic [15:0] ST3 = 16'h0054;
    localparam logic [15:0] ST4 = 16'h1002;
    localparam logic [15:0] ST5 = 16'h0029;
    // flags: busy done illegal
    localparam logic [2:0] FZ = 3'b000;
    localparam logic [2:0] FB = 3'b100;
    localparam logic [2:0] FD = 3'b110;
    localparam logic [2:0] FE = 3'b101;

    wire [24:0] obs1 = {if1.step,
        if1.PCout, if1.MARin, if1.IncPC, if1.Zin, if1.PCin,
        if1.ram_read, if1.MDRin, if1.MDRout, if1.IRin, if1.Grb,
        if1.Gra, if1.Rout, if1.Rin, if1.Yin, if1.Cout, if1.Zlowout,
        if1.alu_op, if1.busy, if1.done, if1.illegal};
    wire [24:0] obs4 = {if4.step,
        if4.PCout, if4.MARin, if4.IncPC, if4.Zin, if4.PCin,
        if4.ram_read, if4.MDRin, if4.MDRout, if4.IRin, if4.Grb,
        if4.Gra, if4.Rout, if4.Rin, if4.Yin, if4.Cout, if4.Zlowout,
        if4.alu_op, if4.busy, if4.done, if4.illegal};
    wire [24:0] obs2 = {if2.step,
        if2.PCout, if2.MARin, if2.IncPC, if2.Zin, if2.PCin,
        if2.ram_read, if2.MDRin, if2.MDRout, if2.IRin, if2.Grb,
        if2.Gra, if2.Rout, if2.Rin, if2.Yin, if2.Cout, if2.Zlowout,
        if2.alu_op, if2.busy, if2.done, if2.illegal};

    wire [4:0] drv1 = {if1.PCout, if1.MDRout, if1.Rout, if1.Cout, if1.Zlowout};
    wire [4:0] drv4 = {if4.PCout, if4.MDRout, if4.Rout, if4.Cout, if4.Zlowout};
    wire [4:0] drv2 = {if2.PCout, if2.MDRout, if2.Rout, if2.Cout, if2.Zlowout};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex(input string tag, input logic [24:0] obs,
                      input logic [3:0] st, input logic [15:0] str,
                      input logic [1:0] op, input logic [2:0] fl);
        chk(tag, {7'd0, obs}, {7'd0, st, str, op, fl});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("excl1", {31'd0, $countones(drv1) <= 1}, 32'd1);
        chk("excl4", {31'd0, $countones(drv4) <= 1}, 32'd1);
        chk("excl2", {31'd0, $countones(drv2) <= 1}, 32'd1);
    endtask

    // one instruction on the MEM_LAT=1 unit; run_v is sampled leaving T5
    task automatic instr1(input string tag, input logic [4:0] opc,
                          input logic [1:0] op, input logic run_v);
        if1.ir_opcode = opc;
        tick(); ex({tag, "_t0"}, obs1, 4'd1, ST0, 2'b00, FB);
        if1.start = 1'b0;
        tick(); ex({tag, "_t1"}, obs1, 4'd2, ST1, 2'b00, FB);
        tick(); ex({tag, "_t2"}, obs1, 4'd4, ST2, 2'b00, FB);
        tick(); ex({tag, "_dec"}, obs1, 4'd5, SN, 2'b00, FB);
        tick(); ex({tag, "_t3"}, obs1, 4'd6, ST3, 2'b00, FB);
        tick(); ex({tag, "_t4"}, obs1, 4'd7, ST4, op, FB);
        tick(); ex({tag, "_t5"}, obs1, 4'd8, ST5, 2'b00, FD);
        if1.run = run_v;
    endtask

    initial begin
        int rr;
        int pc;
        {if1.start, if1.run, if1.mem_ready} = 3'b000;
        {if4.start, if4.run, if4.mem_ready} = 3'b000;
        {if2.start, if2.run, if2.mem_ready} = 3'b000;
        if1.ir_opcode = 5'd0;
        if4.ir_opcode = 5'd0;
        if2.ir_opcode = 5'd0;

        tick();
        tick();
        ex("rst1", obs1, 4'd0, SN, 2'b00, FZ);
        ex("rst4", obs4, 4'd0, SN, 2'b00, FZ);
        ex("rst2", obs2, 4'd0, SN, 2'b00, FZ);
        clear_n = 1'b1;

        if1.start = 1'b1;
        instr1("andi", 5'b01101, 2'b01, 1'b0);
        tick(); ex("andi_idle", obs1, 4'd0, SN, 2'b00, FZ);

        if1.start = 1'b1;
        instr1("addi", 5'b01100, 2'b00, 1'b1);
        instr1("ori", 5'b01110, 2'b10, 1'b0);
        tick(); ex("ori_idle", obs1, 4'd0, SN, 2'b00, FZ);

        if1.start = 1'b1;
        if1.ir_opcode = 5'b11111;
        tick(); ex("ill_t0", obs1, 4'd1, ST0, 2'b00, FB);
        if1.start = 1'b0;
        tick(); ex("ill_t1", obs1, 4'd2, ST1, 2'b00, FB);
        tick(); ex("ill_t2", obs1, 4'd4, ST2, 2'b00, FB);
        tick(); ex("ill_dec", obs1, 4'd5, SN, 2'b00, FB);
        tick(); ex("ill_err", obs1, 4'd9, SN, 2'b00, FE);
        tick(); ex("ill_idle", obs1, 4'd0, SN, 2'b00, FZ);

        if1.start = 1'b1;
        if1.ir_opcode = 5'b01100;
        tick(); ex("ab_t0", obs1, 4'd1, ST0, 2'b00, FB);
        if1.start = 1'b0;
        tick(); ex("ab_t1", obs1, 4'd2, ST1, 2'b00, FB);
        tick(); ex("ab_t2", obs1, 4'd4, ST2, 2'b00, FB);
        tick(); ex("ab_dec", obs1, 4'd5, SN, 2'b00, FB);
        tick(); ex("ab_t3", obs1, 4'd6, ST3, 2'b00, FB);
        clear_n = 1'b0;
        tick(); ex("ab_rst", obs1, 4'd0, SN, 2'b00, FZ);
        clear_n = 1'b1;
        tick(); ex("ab_idle", obs1, 4'd0, SN, 2'b00, FZ);
        if1.start = 1'b1;
        instr1("ab_andi", 5'b01101, 2'b01, 1'b0);
        tick(); ex("ab_end", obs1, 4'd0, SN, 2'b00, FZ);

        rr = 0;
        pc = 0;
        if4.start = 1'b1;
        if4.ir_opcode = 5'b01110;
        tick(); ex("l4_t0", obs4, 4'd1, ST0, 2'b00, FB);
        if4.start = 1'b0;
        tick(); ex("l4_t1", obs4, 4'd2, ST1, 2'b00, FB);
        rr += int'(if4.ram_read);
        pc += int'(if4.PCin);
        for (int i = 0; i < 3; i++) begin
            tick(); ex("l4_t1w", obs4, 4'd3, STW, 2'b00, FB);
            rr += int'(if4.ram_read);
            pc += int'(if4.PCin);
        end
        tick(); ex("l4_t2", obs4, 4'd4, ST2, 2'b00, FB);
        rr += int'(if4.ram_read);
        chk("l4_reads", 32'(rr), 32'd4);
        chk("l4_pcin", 32'(pc), 32'd1);
        tick(); ex("l4_dec", obs4, 4'd5, SN, 2'b00, FB);
        tick(); ex("l4_t3", obs4, 4'd6, ST3, 2'b00, FB);
        tick(); ex("l4_t4", obs4, 4'd7, ST4, 2'b10, FB);
        tick(); ex("l4_t5", obs4, 4'd8, ST5, 2'b00, FD);
        tick(); ex("l4_idle", obs4, 4'd0, SN, 2'b00, FZ);

        if2.start = 1'b1;
        if2.ir_opcode = 5'b01100;
        if2.mem_ready = 1'b0;
        tick(); ex("l2_t0", obs2, 4'd1, ST0, 2'b00, FB);
        if2.start = 1'b0;
        tick(); ex("l2_t1", obs2, 4'd2, ST1, 2'b00, FB);
`ifdef ALU_IMM_SEQ_MEM_READY_EN
        for (int i = 0; i < 5; i++) begin
            tick(); ex("l2_wait", obs2, 4'd3, STW, 2'b00, FB);
            if (i == 4) if2.mem_ready = 1'b1;
        end
`else
        tick(); ex("l2_t1w", obs2, 4'd3, STW, 2'b00, FB);
`endif
        tick(); ex("l2_t2", obs2, 4'd4, ST2, 2'b00, FB);
        tick(); ex("l2_dec", obs2, 4'd5, SN, 2'b00, FB);
        tick(); ex("l2_t3", obs2, 4'd6, ST3, 2'b00, FB);
        tick(); ex("l2_t4", obs2, 4'd7, ST4, 2'b00, FB);
        tick(); ex("l2_t5", obs2, 4'd8, ST5, 2'b00, FD);
        tick(); ex("l2_idle", obs2, 4'd0, SN, 2'b00, FZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
